// File: rtl/switch_word_entry.sv
// ---------------------------------------------------------------------------
// switch_word_entry
//
// Purpose:
//   Lets an operator key in a word one hex nibble at a time on the DE2
//   board. The nibble comes from switch[3:0]. Three active-low push buttons
//   control entry:
//     enter  - shift the current nibble into the word
//     clear  - wipe the word, or abort an offer that is still pending
//     commit - offer the assembled word to the processor
//   Each button is synchronized and debounced on its own, and only its
//   press (debounced 1->0 transition) has any effect. The word under
//   construction is shown live on data_out for the hex display. A committed
//   word is held on data_out with word_valid=1 until the consumer raises
//   word_ready, or until clear aborts the offer.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronized button level must persist before
//                    it is accepted (>= 1)
//   NIBBLES          nibbles per word, 1..15 (nibble_count is 4 bits)
//
// Ports:
//   clk               system clock, rising edge
//   ProcessorReset_L  asynchronous reset, active-low
//   nibble_in  [3:0]  hex digit to enter
//   enter_L           raw enter button, active-low
//   clear_L           raw clear button, active-low
//   commit_L          raw commit button, active-low
//   word_ready        consumer accepts data_out while word_valid=1
//   data_out   [4*NIBBLES-1:0]  assembled word, registered
//   nibble_count [3:0]          nibbles entered, saturates at NIBBLES
//   word_valid                  word offered, registered
//
// Configuration:
//   AUTO_COMMIT_EN  when defined, the enter press that fills the word
//                   offers it immediately, with no commit press needed.
//                   When undefined, only commit starts an offer.
// ---------------------------------------------------------------------------
module switch_word_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NIBBLES         = 8
) (
  input  logic                   clk,
  input  logic                   ProcessorReset_L,
  input  logic [3:0]             nibble_in,
  input  logic                   enter_L,
  input  logic                   clear_L,
  input  logic                   commit_L,
  input  logic                   word_ready,
  output logic [4*NIBBLES-1:0]   data_out,
  output logic [3:0]             nibble_count,
  output logic                   word_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // The counter value that, when incremented, reaches DEBOUNCE_CYCLES.
  // The new level is accepted on that edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] FULL_COUNT = 4'(NIBBLES);

  localparam logic [0:0] ST_ENTRY   = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Button bit order: 0 = enter, 1 = clear, 2 = commit
  logic [2:0] raw_buttons;
  logic [2:0] press;

  assign raw_buttons = {commit_L, clear_L, enter_L};

  // -------------------------------------------------------------------------
  // Button conditioning, one identical channel per button.
  // A 2-flop synchronizer feeds a counter. The counter runs while the
  // synchronized level disagrees with the accepted (debounced) level, and
  // any agreement restarts it, so a bouncing contact never gets through.
  // The press pulse is registered on the same edge that the debounced
  // level falls, so it lasts exactly one cycle. Releases make no pulse.
  // -------------------------------------------------------------------------
  for (genvar b = 0; b < 3; b++) begin : g_button
    logic             sync_a;
    logic             sync_b;
    logic             debounced;
    logic [CNT_W-1:0] db_count;
    logic             press_q;

    always_ff @(posedge clk or negedge ProcessorReset_L) begin
      if (!ProcessorReset_L) begin
        sync_a    <= 1'b1;
        sync_b    <= 1'b1;
        debounced <= 1'b1;
        db_count  <= '0;
        press_q   <= 1'b0;
      end else begin
        sync_a  <= raw_buttons[b];
        sync_b  <= sync_a;
        press_q <= 1'b0;
        if (sync_b == debounced) begin
          db_count <= '0;
        end else if (db_count == CNT_LAST) begin
          debounced <= sync_b;
          db_count  <= '0;
          press_q   <= ~sync_b;
        end else begin
          db_count <= db_count + 1'b1;
        end
      end
    end

    assign press[b] = press_q;
  end

  logic enter_press;
  logic clear_press;
  logic commit_press;

  assign enter_press  = press[0];
  assign clear_press  = press[1];
  assign commit_press = press[2];

  // -------------------------------------------------------------------------
  // Next word value for an enter press. The new nibble goes in at the bottom.
  // Once the word is full, the oldest nibble falls off the top. A one-nibble
  // word simply takes the new digit.
  // -------------------------------------------------------------------------
  logic [4*NIBBLES-1:0] shifted_word;

  if (NIBBLES == 1) begin : g_shift_single
    assign shifted_word = nibble_in;
  end else begin : g_shift_multi
    assign shifted_word = {data_out[4*NIBBLES-5:0], nibble_in};
  end

  // The nibble count saturates once the word is full. Further entries keep
  // shifting, but the count stays at NIBBLES.
  logic [3:0] count_inc;

  always_comb begin
    count_inc = nibble_count;
    if (nibble_count != FULL_COUNT) begin
      count_inc = nibble_count + 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Entry / handshake FSM.
  // ENTRY builds the word. When several presses arrive in the same cycle,
  // clear wins over commit, and commit wins over enter. An empty word is
  // never offered.
  // PENDING freezes data_out and holds word_valid high until the consumer
  // takes the word or clear aborts the offer. Both exits leave the same
  // empty state behind, so a clear that coincides with word_ready counts as
  // a single completed transfer. enter and commit are ignored while pending.
  // -------------------------------------------------------------------------
  logic [0:0] state;

  always_ff @(posedge clk or negedge ProcessorReset_L) begin
    if (!ProcessorReset_L) begin
      state        <= ST_ENTRY;
      data_out     <= '0;
      nibble_count <= '0;
      word_valid   <= 1'b0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (clear_press) begin
            data_out     <= '0;
            nibble_count <= '0;
          end else if (commit_press) begin
            if (nibble_count != 4'd0) begin
              state      <= ST_PENDING;
              word_valid <= 1'b1;
            end
          end else if (enter_press) begin
            data_out     <= shifted_word;
            nibble_count <= count_inc;
`ifdef AUTO_COMMIT_EN
            if (nibble_count == FULL_COUNT - 4'd1) begin
              state      <= ST_PENDING;
              word_valid <= 1'b1;
            end
`else
            // A full word waits in ENTRY for an explicit commit.
`endif
          end
        end

        ST_PENDING: begin
          if (word_ready || clear_press) begin
            state        <= ST_ENTRY;
            word_valid   <= 1'b0;
            data_out     <= '0;
            nibble_count <= '0;
          end
        end

        default: begin
          state        <= ST_ENTRY;
          word_valid   <= 1'b0;
          data_out     <= '0;
          nibble_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_word_entry.sv
// ---------------------------------------------------------------------------
// tb_switch_word_entry
// Self-checking bench for switch_word_entry, built with DEBOUNCE_CYCLES=4
// and NIBBLES=8. The reference model tracks the word as plain arithmetic on
// the presses the bench makes. Define AUTO_COMMIT_EN to run the bench
// against the auto-commit build.
// ---------------------------------------------------------------------------
module tb_switch_word_entry;

  localparam int DB = 4;
  localparam int NB = 8;

  localparam int BTN_ENTER  = 0;
  localparam int BTN_CLEAR  = 1;
  localparam int BTN_COMMIT = 2;

  logic        clk;
  logic        ProcessorReset_L;
  logic [3:0]  nibble_in;
  logic        enter_L;
  logic        clear_L;
  logic        commit_L;
  logic        word_ready;
  logic [31:0] data_out;
  logic [3:0]  nibble_count;
  logic        word_valid;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [31:0] exp_word;
  int          exp_count;
  logic        exp_valid;

  switch_word_entry #(
    .DEBOUNCE_CYCLES(DB),
    .NIBBLES(NB)
  ) dut (
    .clk(clk),
    .ProcessorReset_L(ProcessorReset_L),
    .nibble_in(nibble_in),
    .enter_L(enter_L),
    .clear_L(clear_L),
    .commit_L(commit_L),
    .word_ready(word_ready),
    .data_out(data_out),
    .nibble_count(nibble_count),
    .word_valid(word_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".data"}, data_out, exp_word);
    checkValue({tag, ".count"}, {28'd0, nibble_count}, 32'(exp_count));
    checkValue({tag, ".valid"}, {31'd0, word_valid}, {31'd0, exp_valid});
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_word  = 32'd0;
    exp_count = 0;
    exp_valid = 1'b0;
  endtask

  task automatic model_enter(input logic [3:0] nib);
    if (!exp_valid) begin
      exp_word = exp_word * 32'd16 + 32'(nib);
      if (exp_count < NB) exp_count++;
`ifdef AUTO_COMMIT_EN
      if (exp_count == NB) exp_valid = 1'b1;
`endif
    end
  endtask

  task automatic model_clear();
    model_reset();
  endtask

  task automatic model_commit();
    if (!exp_valid && exp_count != 0) exp_valid = 1'b1;
  endtask

  task automatic model_ready();
    if (exp_valid) model_reset();
  endtask

  task automatic model_press(input int btn, input logic [3:0] nib);
    case (btn)
      BTN_ENTER:  model_enter(nib);
      BTN_CLEAR:  model_clear();
      default:    model_commit();
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_button(input int btn, input logic level);
    case (btn)
      BTN_ENTER:  enter_L  = level;
      BTN_CLEAR:  clear_L  = level;
      default:    commit_L = level;
    endcase
  endtask

  // One clean press and release, long enough to pass the debouncer both
  // ways. The model is updated once the press has taken effect.
  task automatic applyStimulus(input int btn, input logic [3:0] nib);
    nibble_in = nib;
    drive_button(btn, 1'b0);
    tick(DB + 4);
    drive_button(btn, 1'b1);
    tick(DB + 4);
    model_press(btn, nib);
  endtask

  task automatic transfer();
    word_ready = 1'b1;
    tick(1);
    word_ready = 1'b0;
    model_ready();
  endtask

  initial begin
    ProcessorReset_L = 1'b0;
    nibble_in  = 4'h0;
    enter_L    = 1'b1;
    clear_L    = 1'b1;
    commit_L   = 1'b1;
    word_ready = 1'b0;
    model_reset();

    // Reset state
    tick(2);
    checkOutput("reset");
    ProcessorReset_L = 1'b1;
    tick(3);

    // Exact latency: the raw edge lands just after a clock edge. data_out
    // must still be old after 2+DB edges and updated on the next one.
    nibble_in = 4'h1;
    enter_L   = 1'b0;
    tick(DB + 2);
    checkOutput("latency.before");
    tick(1);
    model_enter(4'h1);
    checkOutput("latency.after");
    enter_L = 1'b1;
    tick(DB + 4);

    // Test 1: word 0x12345678, commit, handshake
    for (int i = 2; i <= 8; i++) applyStimulus(BTN_ENTER, 4'(i));
    applyStimulus(BTN_COMMIT, 4'h0);
    checkOutput("t1.commit");
    checkValue("t1.word", data_out, 32'h12345678);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkValue("t1.hold", {31'd0, word_valid}, 32'd1);
    end
    transfer();
    checkOutput("t1.done");

    // Test 2: short press and bouncing contact produce nothing
    applyStimulus(BTN_ENTER, 4'h3);
    nibble_in = 4'hF;
    enter_L = 1'b0;
    tick(3);
    enter_L = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      enter_L = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    enter_L = 1'b1;
    tick(12);
    checkOutput("t2.glitch");

    // Test 3: overflow shifting, and commit of an empty word
    applyStimulus(BTN_CLEAR, 4'h0);
    for (int i = 1; i <= 9; i++) applyStimulus(BTN_ENTER, 4'(i));
`ifndef AUTO_COMMIT_EN
    checkValue("t3.word", data_out, 32'h23456789);
    checkValue("t3.count", {28'd0, nibble_count}, 32'd8);
`endif
    checkOutput("t3.overflow");
    if (exp_valid) transfer();
    applyStimulus(BTN_CLEAR, 4'h0);
    applyStimulus(BTN_COMMIT, 4'h0);
    checkOutput("t3.commit0");

    // Test 4a: abort a pending offer with clear
    applyStimulus(BTN_ENTER, 4'($urandom_range(0, 15)));
    applyStimulus(BTN_ENTER, 4'($urandom_range(0, 15)));
    applyStimulus(BTN_COMMIT, 4'h0);
    checkOutput("t4.pending");
    applyStimulus(BTN_ENTER, 4'h9);
    checkOutput("t4.enterIgnored");
    applyStimulus(BTN_CLEAR, 4'h0);
    checkOutput("t4.abort");

    // Test 4b: clear pulse and word_ready in the same cycle
    for (int i = 0; i < 3; i++) applyStimulus(BTN_ENTER, 4'($urandom_range(0, 15)));
    applyStimulus(BTN_COMMIT, 4'h0);
    checkOutput("t4.pending2");
    clear_L = 1'b0;
    tick(DB + 2);
    word_ready = 1'b1;
    tick(1);
    word_ready = 1'b0;
    model_ready();
    checkOutput("t4.both");
    clear_L = 1'b1;
    tick(DB + 6);
    checkOutput("t4.after");

    // Test 5: asynchronous reset in the middle of a debounce
    for (int i = 0; i < 3; i++) applyStimulus(BTN_ENTER, 4'($urandom_range(1, 15)));
    checkOutput("t5.three");
    nibble_in = 4'h5;
    enter_L = 1'b0;
    tick(3);
    #2;
    ProcessorReset_L = 1'b0;
    #1;
    model_reset();
    checkOutput("t5.async");
    tick(2);
    ProcessorReset_L = 1'b1;
    tick(1);
    enter_L = 1'b1;
    tick(20);
    checkOutput("t5.noPress");
    applyStimulus(BTN_ENTER, 4'h7);
    checkOutput("t5.repress");

`ifdef AUTO_COMMIT_EN
    // Test 6: a full word of 0xA offers itself one cycle after the 8th pulse
    applyStimulus(BTN_CLEAR, 4'h0);
    for (int i = 0; i < 7; i++) applyStimulus(BTN_ENTER, 4'hA);
    nibble_in = 4'hA;
    enter_L = 1'b0;
    tick(DB + 2);
    checkValue("t6.before", {31'd0, word_valid}, 32'd0);
    tick(1);
    model_enter(4'hA);
    checkValue("t6.valid", {31'd0, word_valid}, 32'd1);
    checkValue("t6.word", data_out, 32'hAAAAAAAA);
    enter_L = 1'b1;
    tick(DB + 4);
    transfer();
    checkOutput("t6.done");
`endif

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        applyStimulus(BTN_ENTER, 4'($urandom_range(0, 15)));
      end else if (op == 6) begin
        applyStimulus(BTN_CLEAR, 4'h0);
      end else if (op == 7) begin
        applyStimulus(BTN_COMMIT, 4'h0);
      end else begin
        int waits;
        waits = int'($urandom_range(0, 3));
        for (int w = 0; w < waits; w++) begin
          tick(1);
          checkValue("rand.hold", {31'd0, word_valid}, {31'd0, exp_valid});
        end
        transfer();
      end
      checkOutput("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
